// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one boothMult signed 8x8 multiplier between requesters A and B.
// Optional MULT_ARB_TIMEOUT_EN builds an ARM+WAIT watchdog that aborts with err after TIMEOUT_CYCLES.
module mult_share_arbiter
`ifdef MULT_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic        clk,
  input  logic        Resetn,
  input  logic        reqA,
  input  logic [7:0]  mplierA,
  input  logic [7:0]  mcandA,
  output logic        ackA,
  output logic        doneA,
  input  logic        reqB,
  input  logic [7:0]  mplierB,
  input  logic [7:0]  mcandB,
  output logic        ackB,
  output logic        doneB,
  output logic [15:0] result,
  output logic        err,
  output logic        mStart,
  output logic [7:0]  mMplier,
  output logic [7:0]  mMcand,
  input  logic        mFinish,
  input  logic [15:0] mProduct
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = A, 1 = B
  logic        last_q, last_d;     // requester served most recently
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [15:0] result_q, result_d;
  logic        start_q, start_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        done_a_q, done_a_d;
  logic        done_b_q, done_b_d;
  logic        err_q, err_d;
  logic        grant_b_s;
  logic        timeout_s;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Watchdog counter: cleared in ISSUE, counts every ARM/WAIT cycle.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    case (state_q)
      S_ISSUE: cnt_d = '0;
      S_ARM, S_WAIT: begin
        cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        timeout_s = (cnt_q == CNT_LAST);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // B wins when it alone requests, or on a tie when A was served last.
  assign grant_b_s = reqB & (~reqA | ~last_q);

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reqA || reqB) begin
          owner_d  = grant_b_s;
          last_d   = grant_b_s;
          mplier_d = grant_b_s ? mplierB : mplierA;
          mcand_d  = grant_b_s ? mcandB  : mcandA;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        // A Finish level still high here belongs to the previous operation.
        if (timeout_s) begin
          result_d = 16'h0000;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else if (!mFinish) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ARM;
        end
      end
      S_WAIT: begin
        if (mFinish) begin
          result_d = mProduct;
          state_d  = S_DONE;
        end else if (timeout_s) begin
          result_d = 16'h0000;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    start_d  = (state_d == S_ISSUE);
    ack_a_d  = (state_d == S_ISSUE) && !owner_d;
    ack_b_d  = (state_d == S_ISSUE) &&  owner_d;
    done_a_d = (state_d == S_DONE)  && !owner_d;
    done_b_d = (state_d == S_DONE)  &&  owner_d;
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      mplier_q <= 8'h00;
      mcand_q  <= 8'h00;
      result_q <= 16'h0000;
      start_q  <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      start_q  <= start_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      err_q    <= err_d;
    end
  end

  assign mStart  = start_q;
  assign mMplier = mplier_q;
  assign mMcand  = mcand_q;
  assign ackA    = ack_a_q;
  assign ackB    = ack_b_q;
  assign doneA   = done_a_q;
  assign doneB   = done_b_q;
  assign result  = result_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural boothMult stand-in.
// The stand-in drops Finish one edge late, so ARM must discard a stale Finish level.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        Resetn;
  logic        reqA, reqB;
  logic [7:0]  mplierA, mcandA, mplierB, mcandB;
  logic        ackA, ackB, doneA, doneB, err, mStart, mFinish;
  logic [7:0]  mMplier, mMcand;
  logic [15:0] result, mProduct;

  int n_pass  = 0;
  int n_total = 0;
  int lat     = 2;
  bit stuck   = 1'b0;

  always #5 clk = ~clk;

`ifdef MULT_ARB_TIMEOUT_EN
  mult_share_arbiter #(.TIMEOUT_CYCLES(8)) dut (
`else
  mult_share_arbiter dut (
`endif
    .clk(clk), .Resetn(Resetn),
    .reqA(reqA), .mplierA(mplierA), .mcandA(mcandA), .ackA(ackA), .doneA(doneA),
    .reqB(reqB), .mplierB(mplierB), .mcandB(mcandB), .ackB(ackB), .doneB(doneB),
    .result(result), .err(err), .mStart(mStart), .mMplier(mMplier), .mMcand(mMcand),
    .mFinish(mFinish), .mProduct(mProduct));

  // Multiplier stand-in: product appears lat+1 edges after Finish drops.
  logic        pend_q, busy_q;
  int          cnt_q;
  logic [15:0] prod_pend_q;
  always @(posedge clk) begin
    if (!Resetn) begin
      mFinish <= 1'b0; mProduct <= 16'h0000; pend_q <= 1'b0; busy_q <= 1'b0; cnt_q <= 0;
      prod_pend_q <= 16'h0000;
    end else if (mStart) begin
      pend_q      <= 1'b1;
      busy_q      <= 1'b1;
      cnt_q       <= lat;
      prod_pend_q <= $signed(mMplier) * $signed(mMcand);
    end else begin
      if (pend_q) begin
        pend_q  <= 1'b0;
        mFinish <= 1'b0;
      end else if (busy_q) begin
        if (cnt_q == 0) begin
          busy_q   <= 1'b0;
          mFinish  <= !stuck;
          mProduct <= prod_pend_q;
        end else begin
          cnt_q <= cnt_q - 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    reqA = 1'b0; reqB = 1'b0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
  endtask

  // One operation from a single requester, checked end to end.
  task automatic run_op(input bit own_b, input logic [7:0] mpl, input logic [7:0] mc,
                        input logic [15:0] exp, input string nm);
    int t;
    int starts;
    if (own_b) begin reqB = 1'b1; mplierB = mpl; mcandB = mc; end
    else       begin reqA = 1'b1; mplierA = mpl; mcandA = mc; end
    t = 0;
    do begin @(negedge clk); t++; end while (!(ackA || ackB) && t < 10);
    check({nm, "_ack"},    {30'd0, ackA, ackB}, own_b ? 32'd1 : 32'd2);
    check({nm, "_start"},  {31'd0, mStart}, 32'd1);
    check({nm, "_opnds"},  {16'd0, mMplier, mMcand}, {16'd0, mpl, mc});
    reqA = 1'b0; reqB = 1'b0;
    starts = 0; t = 0;
    do begin
      @(negedge clk); t++;
      if (mStart) starts++;
    end while (!(doneA || doneB) && t < 60);
    check({nm, "_restart"}, starts, 32'd0);
    check({nm, "_done"},    {30'd0, doneA, doneB}, own_b ? 32'd1 : 32'd2);
    check({nm, "_result"},  {16'd0, result}, {16'd0, exp});
    check({nm, "_err"},     {31'd0, err}, 32'd0);
    @(negedge clk);
    check({nm, "_hold"},    {14'd0, doneA, doneB, result}, {16'd0, exp});
  endtask

  typedef struct {
    bit          own_b;
    logic [7:0]  mpl;
    logic [7:0]  mc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t;
    bit seen_dn;
    vecs[0] = '{1'b0, 8'h7F, 8'h03, 16'h017D};  //  127 *   3 =   381
    vecs[1] = '{1'b1, 8'hFB, 8'h06, 16'hFFE2};  //   -5 *   6 =   -30
    vecs[2] = '{1'b0, 8'h80, 8'h80, 16'h4000};  // -128 * -128 = 16384
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 16'hC080};  //  127 * -128 = -16256
    vecs[4] = '{1'b0, 8'h00, 8'hFF, 16'h0000};  //    0 *  -1 =     0
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};  //   -1 *  -1 =     1
    mplierA = 8'h00; mcandA = 8'h00; mplierB = 8'h00; mcandB = 8'h00;

    do_reset();
    @(negedge clk);
    check("reset_outs", {ackA, ackB, doneA, doneB, err, mStart, mMplier, mMcand, result},
          {6'd0, 8'd0, 8'd0, 16'd0});

    for (int i = 0; i < 6; i++) run_op(vecs[i].own_b, vecs[i].mpl, vecs[i].mc, vecs[i].exp, $sformatf("vec%0d", i));

    // Both requests held continuously after reset: A, B, A, B.
    do_reset();
    mplierA = 8'h02; mcandA = 8'h03; mplierB = 8'h04; mcandB = 8'h05;
    reqA = 1'b1; reqB = 1'b1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!(ackA || ackB) && t < 10);
      check($sformatf("tie%0d_ack", g), {30'd0, ackA, ackB}, (g % 2) ? 32'd1 : 32'd2);
      t = 0;
      do begin @(negedge clk); t++; end while (!(doneA || doneB) && t < 60);
      check($sformatf("tie%0d_done", g), {30'd0, doneA, doneB}, (g % 2) ? 32'd1 : 32'd2);
      check($sformatf("tie%0d_result", g), {16'd0, result}, (g % 2) ? 32'h0014 : 32'h0006);
    end
    reqA = 1'b0; reqB = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while the multiplier is still busy.
    lat = 8;
    reqA = 1'b1; mplierA = 8'h09; mcandA = 8'h09;
    t = 0;
    do begin @(negedge clk); t++; end while (!ackA && t < 10);
    reqA = 1'b0;
    repeat (4) @(negedge clk);
    Resetn = 1'b0;
    @(negedge clk);
    Resetn = 1'b1;
    check("rst_mid_outs", {ackA, ackB, doneA, doneB, err, mStart, mMplier, mMcand, result},
          {6'd0, 8'd0, 8'd0, 16'd0});
    seen_dn = 1'b0;
    repeat (20) begin @(negedge clk); if (doneA || doneB || ackA || ackB) seen_dn = 1'b1; end
    check("rst_mid_quiet", {31'd0, seen_dn}, 32'd0);
    lat = 2;
    run_op(1'b0, 8'h01, 8'h01, 16'h0001, "post_rst");

`ifdef MULT_ARB_TIMEOUT_EN
    // Finish never rises: abort 8 cycles after ARM entry.
    stuck = 1'b1;
    reqA = 1'b1; mplierA = 8'h05; mcandA = 8'h05;
    t = 0;
    do begin @(negedge clk); t++; end while (!ackA && t < 10);
    reqA = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!doneA && t < 40);
    check("to_latency", t, 32'd9);
    check("to_err",     {31'd0, err}, 32'd1);
    check("to_result",  {16'd0, result}, 32'd0);
    stuck = 1'b0;
    run_op(1'b0, 8'h03, 8'h04, 16'h000C, "after_to");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
